// File: rtl/ps2_rx_frame.sv
// PS/2 device-to-host receive front end: pin synchronizers, clock de-glitch
// filter, 11-bit frame deserializer with start/parity/stop checking, and a
// valid/ack byte handshake with sticky overrun and timeout flags.
module ps2_rx_frame #(
    parameter int unsigned FILTER_LEN     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 200000
) (
    input  logic        Bus2IP_Clk,
    input  logic        Bus2IP_Resetn,
    input  logic        ps2_clk_in,
    input  logic        ps2_data_in,
    input  logic        rx_ack,
    input  logic        err_clr,
    output logic [7:0]  rx_data,
    output logic [10:0] rx_frame,
    output logic        rx_valid,
    output logic        rx_parity_err,
    output logic        rx_frame_err,
    output logic        rx_overrun,
    output logic        rx_timeout,
    output logic        busy
);

    localparam int unsigned FRAME_W = 11;
    localparam int unsigned BCNT_W  = 4;
    localparam int unsigned FCNT_W  = $clog2(FILTER_LEN);
    localparam int unsigned TO_W    = $clog2(TIMEOUT_CYCLES);

    localparam logic [FCNT_W-1:0] FILT_MAX = FCNT_W'(FILTER_LEN - 1);
    localparam logic [TO_W-1:0]   TO_MAX   = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [BCNT_W-1:0] LAST_BIT = BCNT_W'(FRAME_W - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [1:0]         clk_sync;
    logic [1:0]         data_sync;
    logic               clk_s;
    logic               data_s;
    logic               clk_f;
    logic               clk_f_d;
    logic [FCNT_W-1:0]  filt_cnt;
    logic [FRAME_W-1:0] shift_reg;
    logic [BCNT_W-1:0]  bit_cnt;
    logic [TO_W-1:0]    to_cnt;

    logic fall_c;
    logic shift_en_c;
    logic load_c;
    logic overrun_set_c;
    logic timeout_set_c;

    assign clk_s  = clk_sync[1];
    assign data_s = data_sync[1];
    assign fall_c = clk_f_d & ~clk_f;

    // Two-flop synchronizers; idle-high so reset looks like an idle bus.
    always_ff @(posedge Bus2IP_Clk or negedge Bus2IP_Resetn) begin
        if (!Bus2IP_Resetn) begin
            clk_sync  <= 2'b11;
            data_sync <= 2'b11;
        end else begin
            clk_sync  <= {clk_sync[0], ps2_clk_in};
            data_sync <= {data_sync[0], ps2_data_in};
        end
    end

    // Filtered clock follows the synced clock only after FILTER_LEN stable cycles.
    always_ff @(posedge Bus2IP_Clk or negedge Bus2IP_Resetn) begin
        if (!Bus2IP_Resetn) begin
            clk_f    <= 1'b1;
            clk_f_d  <= 1'b1;
            filt_cnt <= '0;
        end else begin
            clk_f_d <= clk_f;
            if (clk_s != clk_f) begin
                if (filt_cnt == FILT_MAX) begin
                    clk_f    <= clk_s;
                    filt_cnt <= '0;
                end else begin
                    filt_cnt <= filt_cnt + FCNT_W'(1);
                end
            end else begin
                filt_cnt <= '0;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge Bus2IP_Clk or negedge Bus2IP_Resetn) begin
        if (!Bus2IP_Resetn) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next state and datapath control strobes.
    always_comb begin
        state_nxt     = state;
        shift_en_c    = 1'b0;
        load_c        = 1'b0;
        overrun_set_c = 1'b0;
        timeout_set_c = 1'b0;
        case (state)
            S_IDLE: begin
                if (fall_c) begin
                    shift_en_c = 1'b1;
                    state_nxt  = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (fall_c) begin
                    shift_en_c = 1'b1;
                    if (bit_cnt == LAST_BIT) begin
                        state_nxt = S_DONE;
                    end
                end else if (to_cnt == TO_MAX) begin
                    timeout_set_c = 1'b1;
                    state_nxt     = S_IDLE;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
                if (!rx_valid || rx_ack) begin
                    load_c = 1'b1;
                end else begin
                    overrun_set_c = 1'b1;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Shift register (LSB arrives first, enters at the top), bit and timeout counters.
    always_ff @(posedge Bus2IP_Clk or negedge Bus2IP_Resetn) begin
        if (!Bus2IP_Resetn) begin
            shift_reg <= '0;
            bit_cnt   <= '0;
            to_cnt    <= '0;
        end else begin
            if (shift_en_c) begin
                shift_reg <= {data_s, shift_reg[FRAME_W-1:1]};
            end
            if (state == S_IDLE) begin
                bit_cnt <= shift_en_c ? BCNT_W'(1) : '0;
            end else if (shift_en_c) begin
                bit_cnt <= bit_cnt + BCNT_W'(1);
            end
            if (state != S_SHIFT || fall_c) begin
                to_cnt <= '0;
            end else if (to_cnt != TO_MAX) begin
                to_cnt <= to_cnt + TO_W'(1);
            end
        end
    end

    // Held byte, error qualifiers and valid/ack handshake.
    always_ff @(posedge Bus2IP_Clk or negedge Bus2IP_Resetn) begin
        if (!Bus2IP_Resetn) begin
            rx_data       <= '0;
            rx_frame      <= '0;
            rx_parity_err <= 1'b0;
            rx_frame_err  <= 1'b0;
            rx_valid      <= 1'b0;
        end else begin
            if (load_c) begin
                rx_frame      <= shift_reg;
                rx_data       <= shift_reg[8:1];
                rx_parity_err <= ~(^shift_reg[9:1]);
                rx_frame_err  <= shift_reg[0] | ~shift_reg[10];
                rx_valid      <= 1'b1;
            end else if (rx_ack) begin
                rx_valid <= 1'b0;
            end
        end
    end

    // Sticky error flags (a set event beats a same-cycle clear) and busy.
    always_ff @(posedge Bus2IP_Clk or negedge Bus2IP_Resetn) begin
        if (!Bus2IP_Resetn) begin
            rx_overrun <= 1'b0;
            rx_timeout <= 1'b0;
            busy       <= 1'b0;
        end else begin
            if (overrun_set_c) begin
                rx_overrun <= 1'b1;
            end else if (err_clr) begin
                rx_overrun <= 1'b0;
            end
            if (timeout_set_c) begin
                rx_timeout <= 1'b1;
            end else if (err_clr) begin
                rx_timeout <= 1'b0;
            end
            busy <= (state_nxt == S_SHIFT);
        end
    end

endmodule

// File: tb/tb_ps2_rx_frame.sv
// Bench for ps2_rx_frame: drives PS/2 frames on the pins and compares every
// output against a transaction-level model of the receiver.
module tb_ps2_rx_frame;

    localparam int unsigned FLEN = 8;
    localparam int unsigned TOUT = 400;
    localparam int unsigned HALF = 30;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pclk = 1'b1;
    logic        pdat = 1'b1;
    logic        rx_ack = 1'b0;
    logic        err_clr = 1'b0;
    logic [7:0]  rx_data;
    logic [10:0] rx_frame;
    logic        rx_valid;
    logic        rx_parity_err;
    logic        rx_frame_err;
    logic        rx_overrun;
    logic        rx_timeout;
    logic        busy;

    int total = 0;
    int bad = 0;

    logic        exp_valid;
    logic [7:0]  exp_data;
    logic [10:0] exp_frame;
    logic        exp_perr;
    logic        exp_ferr;
    logic        exp_ovr;
    logic        exp_to;

    ps2_rx_frame #(
        .FILTER_LEN     (FLEN),
        .TIMEOUT_CYCLES (TOUT)
    ) dut (
        .Bus2IP_Clk    (clk),
        .Bus2IP_Resetn (rst_n),
        .ps2_clk_in    (pclk),
        .ps2_data_in   (pdat),
        .rx_ack        (rx_ack),
        .err_clr       (err_clr),
        .rx_data       (rx_data),
        .rx_frame      (rx_frame),
        .rx_valid      (rx_valid),
        .rx_parity_err (rx_parity_err),
        .rx_frame_err  (rx_frame_err),
        .rx_overrun    (rx_overrun),
        .rx_timeout    (rx_timeout),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check_eq({tag, "_valid"}, 32'(rx_valid), 32'(exp_valid));
        check_eq({tag, "_data"},  32'(rx_data), 32'(exp_data));
        check_eq({tag, "_frame"}, 32'(rx_frame), 32'(exp_frame));
        check_eq({tag, "_perr"},  32'(rx_parity_err), 32'(exp_perr));
        check_eq({tag, "_ferr"},  32'(rx_frame_err), 32'(exp_ferr));
        check_eq({tag, "_ovr"},   32'(rx_overrun), 32'(exp_ovr));
        check_eq({tag, "_tout"},  32'(rx_timeout), 32'(exp_to));
        check_eq({tag, "_busy"},  32'(busy), 32'(0));
    endtask

    function automatic void model_reset();
        exp_valid = 1'b0;
        exp_data  = '0;
        exp_frame = '0;
        exp_perr  = 1'b0;
        exp_ferr  = 1'b0;
        exp_ovr   = 1'b0;
        exp_to    = 1'b0;
    endfunction

    // Frame as a device sends it: start, 8 data bits LSB first, odd parity, stop.
    function automatic logic [10:0] make_frame(input logic [7:0] b, input bit bad_par,
                                                input bit bad_stop, input bit bad_start);
        int ones;
        logic par;
        ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(b[i]);
        par = (ones % 2 == 0) ? 1'b1 : 1'b0;
        if (bad_par) par = ~par;
        return {bad_stop ? 1'b0 : 1'b1, par, b, bad_start ? 1'b1 : 1'b0};
    endfunction

    // Receiver behaviour at the end of a complete frame.
    function automatic void model_complete(input logic [10:0] f, input bit ack);
        int ones;
        ones = 0;
        for (int i = 1; i <= 9; i++) ones += int'(f[i]);
        if (!exp_valid || ack) begin
            exp_frame = f;
            exp_data  = f[8:1];
            exp_perr  = (ones % 2 == 0);
            exp_ferr  = (f[0] != 1'b0) || (f[10] != 1'b1);
            exp_valid = 1'b1;
        end else begin
            exp_ovr = 1'b1;
        end
    endfunction

    // Drive the first n bits of a frame; on the 11th, check latency and optionally ack in DONE.
    task automatic send_bits(input logic [10:0] f, input int n, input bit ack_done);
        for (int i = 0; i < n; i++) begin
            pdat = f[i];
            repeat (HALF) @(negedge clk);
            pclk = 1'b0;
            if (i == 10) begin
                repeat (FLEN + 3) @(negedge clk);
                if (!exp_valid) check_eq("lat_early", 32'(rx_valid), 32'(0));
                if (ack_done) rx_ack = 1'b1;
                @(negedge clk);
                rx_ack = 1'b0;
                model_complete(f, ack_done);
                check_eq("lat_rise", 32'(rx_valid), 32'(1));
                repeat (HALF - FLEN - 4) @(negedge clk);
            end else begin
                repeat (HALF) @(negedge clk);
            end
            pclk = 1'b1;
        end
        pdat = 1'b1;
        repeat (HALF) @(negedge clk);
    endtask

    task automatic do_ack();
        rx_ack = 1'b1;
        @(negedge clk);
        rx_ack = 1'b0;
        exp_valid = 1'b0;
        @(negedge clk);
        check_all("ack");
    endtask

    task automatic do_clr();
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        exp_ovr = 1'b0;
        exp_to  = 1'b0;
        @(negedge clk);
        check_all("clr");
    endtask

    initial begin
        logic [10:0] f;
        int r;
        model_reset();
        repeat (3) @(negedge clk);
        check_all("rst");
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // Clean byte 0x4B
        send_bits(make_frame(8'h4B, 0, 0, 0), 11, 0);
        check_all("b4b");
        check_eq("b4b_raw", 32'(rx_frame), 32'h696);
        do_ack();

        // Parity error, then framing error
        send_bits(make_frame(8'h4B, 1, 0, 0), 11, 0);
        check_all("par");
        check_eq("par_flag", 32'(rx_parity_err), 32'(1));
        do_ack();
        send_bits(make_frame(8'h4B, 0, 1, 0), 11, 0);
        check_all("stp");
        check_eq("stp_flag", 32'(rx_frame_err), 32'(1));
        do_ack();

        // Overrun: second frame arrives with no ack
        send_bits(make_frame(8'h1C, 0, 0, 0), 11, 0);
        send_bits(make_frame(8'h32, 0, 0, 0), 11, 0);
        check_all("ovr");
        check_eq("ovr_hold", 32'(rx_data), 32'h1C);
        check_eq("ovr_flag", 32'(rx_overrun), 32'(1));
        do_clr();

        // Ack in the DONE cycle of a new frame
        send_bits(make_frame(8'h32, 0, 0, 0), 11, 1);
        check_all("ackdone");
        check_eq("ackdone_data", 32'(rx_data), 32'h32);
        do_ack();

        // Timeout after 5 bits, then a good frame
        send_bits(make_frame(8'hA5, 0, 0, 0), 5, 0);
        check_eq("to_busy", 32'(busy), 32'(1));
        repeat (TOUT + 10) @(negedge clk);
        exp_to = 1'b1;
        check_all("tout");
        send_bits(make_frame(8'h29, 0, 0, 0), 11, 0);
        check_all("after_to");
        check_eq("after_to_data", 32'(rx_data), 32'h29);
        do_ack();
        do_clr();

        // Short low glitch must not start a frame
        pclk = 1'b0;
        repeat (3) @(negedge clk);
        pclk = 1'b1;
        repeat (20) @(negedge clk);
        check_all("glitch");
        send_bits(make_frame(8'h5A, 0, 0, 0), 11, 0);
        check_all("post_glitch");

        // Reset mid-frame with a byte held
        send_bits(make_frame(8'h11, 1, 0, 0), 11, 0);
        send_bits(make_frame(8'hC3, 0, 0, 0), 4, 0);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("midrst");
        pclk = 1'b1;
        pdat = 1'b1;
        repeat (HALF) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        send_bits(make_frame(8'h7E, 0, 0, 0), 11, 0);
        check_all("post_rst");
        do_ack();

        // Randomized frames, errors and handshake actions
        for (int k = 0; k < 12; k++) begin
            f = make_frame(8'($urandom), ($urandom % 4) == 0, ($urandom % 8) == 0,
                           ($urandom % 8) == 0);
            send_bits(f, 11, ($urandom % 4) == 0);
            check_all("rnd");
            r = int'($urandom % 4);
            if (r < 2) do_ack();
            else if (r == 2) do_clr();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ps2_rx_frame.md
Name: ps2_rx_frame

Overview:
Line-level PS/2 receive front end, directly upstream of the PS2 bus peripheral's receive path. Synchronizes and de-glitches the raw PS/2 clock and data pins, deserializes 11-bit device-to-host frames on falling PS/2 clock edges, and checks start, parity and stop bits. Presents each byte with a valid/ack handshake, plus the raw frame consumed by the peripheral's bitsReceived register.

Parameters:
FILTER_LEN, 8, consecutive Bus2IP_Clk cycles a synchronized PS/2 clock level must persist before the filtered clock follows it (range 2..255)
TIMEOUT_CYCLES, 200000, max Bus2IP_Clk cycles between falling edges inside a frame before abort (2 ms at 100 MHz)

Ports:
Bus2IP_Clk  in  1  system clock, 100 MHz
Bus2IP_Resetn  in  1  asynchronous, active-low reset
ps2_clk_in  in  1  raw PS/2 clock pin, asynchronous
ps2_data_in  in  1  raw PS/2 data pin, asynchronous
rx_ack  in  1  consumer accepts the current byte
err_clr  in  1  clears the sticky rx_overrun and rx_timeout flags
rx_data  out  8  received byte
rx_frame  out  11  raw frame: [0]=start, [8:1]=data LSB first, [9]=parity, [10]=stop
rx_valid  out  1  rx_data, rx_frame and error flags are valid; held until acked
rx_parity_err  out  1  odd-parity check failed for the held frame
rx_frame_err  out  1  start!=0 or stop!=1 for the held frame
rx_overrun  out  1  sticky: a frame completed while rx_valid=1 with no ack
rx_timeout  out  1  sticky: a frame was aborted by timeout
busy  out  1  high while in SHIFT

Behaviour:
- Reset (Bus2IP_Resetn=0, asynchronous): all outputs 0. Filtered clock=1, sync FFs=1, bit count=0, state IDLE. Reset mid-frame discards the partial frame.
- Sync: 2-FF synchronizer on each pin.
- Filter: a counter runs while the synced clock differs from the filtered clock and clears otherwise. When the count reaches FILTER_LEN-1, the filtered clock takes the synced value. A glitch shorter than FILTER_LEN cycles produces no edge.
- Falling edge: filtered clock 1->0, detected as a single-cycle strobe. On the strobe, synced data is shifted in at bit 10 of the shift register (right shift).
- FSM IDLE: on a strobe, capture bit, count=1, go to SHIFT. The start bit is accepted whatever its value; it is checked at the end.
- FSM SHIFT: each strobe shifts one bit and increments count. The timeout counter resets on every strobe.
  - When count reaches 11, go to DONE.
  - If the timeout counter reaches TIMEOUT_CYCLES-1, go to IDLE, set rx_timeout, discard the frame, and leave rx_valid unchanged.
- FSM DONE (1 cycle), then IDLE:
  - If rx_valid=0, or rx_ack=1 this cycle: load rx_frame, rx_data=shift[8:1], parity_err = ~(^shift[9:1]), frame_err = shift[0] | ~shift[10], and set rx_valid=1.
  - Otherwise: discard the new frame, set rx_overrun, and leave the held data unchanged.
- Latency: rx_valid rises 2 Bus2IP_Clk cycles after the stop-bit strobe (strobe cycle + DONE).
- Frames with parity or framing errors are still delivered; the error flags qualify the byte.
- Handshake: rx_ack with rx_valid=1 clears rx_valid next cycle, unless DONE loads in the same cycle, in which case rx_valid stays 1 with the new data. rx_ack with rx_valid=0 is ignored.
- err_clr clears the sticky flags next cycle. If err_clr and a set event occur in the same cycle, the set wins.
- Counter widths: bit count 4 bits; timeout counter $clog2(TIMEOUT_CYCLES) bits, saturating, never wrapping.

Test Plan:
- Byte 0x4B, PS/2 clock 12.5 kHz, odd parity 1 -> rx_valid=1, rx_data=0x4B, rx_frame=0x696, both error flags 0, rx_valid asserted 2 cycles after the 11th falling edge.
- 0x4B with parity bit 0 -> rx_data=0x4B, rx_parity_err=1. Separately, stop bit 0 -> rx_frame_err=1.
- Two frames 0x1C then 0x32, no rx_ack -> rx_data stays 0x1C, rx_overrun=1. err_clr -> rx_overrun=0.
- rx_ack asserted in the DONE cycle of the second frame -> rx_valid stays 1, rx_data=0x32, rx_overrun=0.
- 5 falling edges then clock held high for 200000 cycles -> rx_timeout=1, busy=0, rx_valid=0. A subsequent full 0x29 frame is received correctly.
- 3-cycle low glitch on ps2_clk_in -> no bit shifted, busy stays 0. Bus2IP_Resetn pulsed low mid-frame -> all outputs 0, and the next full frame decodes correctly.
